// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, arbitrates the single ROM read port
// between fetch and a debug reader, and feeds decode through a one-entry output register.
module inst_fetch_ctrl #(
    parameter logic [31:0] P_RESET_PC     = 32'h0000_0000,
    parameter int          P_ROM_DEPTH    = 64,
    parameter int          P_DBG_MAX_WAIT = 8
) (
    input  logic        iClk,
    input  logic        iRst_n,
    output logic [31:0] oRomAddr,
    input  logic [31:0] iRomData,
    output logic        oInstValid,
    input  logic        iInstReady,
    output logic [31:0] oInst,
    output logic [31:0] oInstPc,
    output logic        oOutOfRange,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPc,
    input  logic        iDbgReq,
    input  logic [31:0] iDbgAddr,
    output logic        oDbgAck,
    output logic [31:0] oDbgData
);

    localparam int          LP_CW        = $clog2(P_DBG_MAX_WAIT + 1);
    localparam logic [31:0] LP_ROM_BYTES = 32'(P_ROM_DEPTH * 4);
    localparam logic [31:0] LP_NOP       = 32'h0000_0013;
    localparam logic [LP_CW-1:0] LP_CNT_MAX = LP_CW'(P_DBG_MAX_WAIT);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic             r_inst_valid;
    logic [31:0]      r_inst;
    logic [31:0]      r_inst_pc;
    logic             r_out_of_range;
    logic             r_dbg_ack;
    logic [31:0]      r_dbg_data;
    logic [LP_CW-1:0] r_cnt;

    logic        w_run;
    logic        w_load;
    logic        w_fetch_need;
    logic        w_dbg_grant;
    logic [31:0] w_dbg_addr;
    logic [31:0] w_redirect_pc;
    logic        w_pc_oor;
    logic        w_unused;

    always_comb begin
        w_run         = (r_state == S_RUN);
        w_load        = w_run && (!r_inst_valid || iInstReady);
        w_fetch_need  = w_load && !iRedirect;
        // A starved debug request wins even against a fetch once its wait saturates.
        w_dbg_grant   = w_run && iDbgReq && !r_dbg_ack &&
                        (!w_fetch_need || (r_cnt == LP_CNT_MAX));
        w_dbg_addr    = {iDbgAddr[31:2], 2'b00};
        w_redirect_pc = {iRedirectPc[31:2], 2'b00};
        w_pc_oor      = (r_pc >= LP_ROM_BYTES);
        oRomAddr      = w_dbg_grant ? w_dbg_addr : r_pc;
    end

    assign w_unused = ^{iDbgAddr[1:0], iRedirectPc[1:0]};

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state        <= S_BOOT;
            r_pc           <= P_RESET_PC;
            r_inst_valid   <= 1'b0;
            r_inst         <= 32'h0;
            r_inst_pc      <= 32'h0;
            r_out_of_range <= 1'b0;
            r_dbg_ack      <= 1'b0;
            r_dbg_data     <= 32'h0;
            r_cnt          <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                    if (iRedirect) begin
                        r_pc <= w_redirect_pc;
                    end
                end
                S_RUN: begin
                    r_dbg_ack <= w_dbg_grant;
                    if (w_dbg_grant) begin
                        r_dbg_data <= iRomData;
                    end

                    if (!iDbgReq || w_dbg_grant) begin
                        r_cnt <= '0;
                    end else if (!r_dbg_ack && (r_cnt != LP_CNT_MAX)) begin
                        r_cnt <= r_cnt + LP_CW'(1);
                    end

                    if (iRedirect) begin
                        r_pc         <= w_redirect_pc;
                        r_inst_valid <= 1'b0;
                    end else if (w_fetch_need && !w_dbg_grant) begin
                        r_inst         <= w_pc_oor ? LP_NOP : iRomData;
                        r_inst_pc      <= r_pc;
                        r_out_of_range <= w_pc_oor;
                        r_inst_valid   <= 1'b1;
                        r_pc           <= r_pc + 32'd4;
                    end else if (w_fetch_need) begin
                        // Forced debug grant stole the port: the slot empties, PC holds.
                        r_inst_valid <= 1'b0;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

    assign oInstValid  = r_inst_valid;
    assign oInst       = r_inst;
    assign oInstPc     = r_inst_pc;
    assign oOutOfRange = r_out_of_range;
    assign oDbgAck     = r_dbg_ack;
    assign oDbgData    = r_dbg_data;

endmodule
